gpr_dump_reader: RTL and testbench

//  Debug-side reader for the CPU general-purpose register file. On a start pulse it

---
 rtl/gpr_dump_reader.sv | 142 ++++++++++++++
 tb/tb_gpr_dump_reader.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_dump_reader.sv
// Debug-side GPR dump: walks the registers selected by a mask through one regfile
// read port and streams {addr,data,last} beats on a valid/ready interface.
module gpr_dump_reader #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int NUM_REGS   = 32,
  parameter int INCLUDE_R0 = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [NUM_REGS-1:0] sel_mask,
  output logic [ADDR_W-1:0]   rf_rd_addr,
  input  logic [DATA_W-1:0]   rf_rd_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  // state | meaning
  // IDLE  | waiting for start
  // SCAN  | capturing one selected register per free output slot
  // DRAIN | final beat captured, waiting for its handshake
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic                done_q, done_d;
  logic [NUM_REGS-1:0] start_mask;
  logic [NUM_REGS-1:0] rest;
  logic                slot_free;

  function automatic logic [ADDR_W-1:0] lowest_set(input logic [NUM_REGS-1:0] v);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (v[i]) r = ADDR_W'(i);
    end
    return r;
  endfunction

  always_comb begin
    start_mask = sel_mask;
    if (INCLUDE_R0 == 0) start_mask[0] = 1'b0;
  end

  // Registers still to dump once the current index is captured.
  assign rest      = pending_q & ~(NUM_REGS'(1) << idx_q);
  assign slot_free = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    if (abort) begin
      state_d     = IDLE;
      pending_d   = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (start_mask == '0) begin
              done_d = 1'b1;
            end else begin
              pending_d = start_mask;
              idx_d     = lowest_set(start_mask);
              state_d   = SCAN;
            end
          end
        end
        SCAN: begin
          if (slot_free) begin
            out_valid_d = 1'b1;
            out_addr_d  = idx_q;
            out_data_d  = rf_rd_data;
            out_last_d  = (rest == '0);
            pending_d   = rest;
            if (rest == '0) state_d = DRAIN;
            else            idx_d   = lowest_set(rest);
          end
        end
        DRAIN: begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign rf_rd_addr = idx_q;
  assign out_valid  = out_valid_q;
  assign out_addr   = out_addr_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_gpr_dump_reader.sv
// Self-checking bench for gpr_dump_reader: table of masks, directed corner
// sequences, and randomized dumps scored against an ascending-set-bit model.
module tb_gpr_dump_reader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start, start_b, abort, out_ready;
  logic [31:0] sel_mask;
  logic [4:0]  rd_a, rd_b, oaddr_a, oaddr_b;
  logic [31:0] rdata_a, rdata_b, odata_a, odata_b;
  logic        ovalid_a, olast_a, busy_a, done_a;
  logic        ovalid_b, olast_b, busy_b, done_b;

  logic [31:0] rf     [32];
  logic [31:0] rf_img [32];
  logic        load_all, wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  always @(posedge clk) begin
    if (load_all)   rf <= rf_img;
    else if (wr_en) rf[wr_addr] <= wr_data;
  end
  assign rdata_a = rf[rd_a];
  assign rdata_b = rf[rd_b];

  gpr_dump_reader #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .INCLUDE_R0(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sel_mask(sel_mask),
    .rf_rd_addr(rd_a), .rf_rd_data(rdata_a), .out_valid(ovalid_a), .out_ready(out_ready),
    .out_addr(oaddr_a), .out_data(odata_a), .out_last(olast_a), .busy(busy_a), .done(done_a));

  gpr_dump_reader #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .INCLUDE_R0(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .sel_mask(sel_mask),
    .rf_rd_addr(rd_b), .rf_rd_data(rdata_b), .out_valid(ovalid_b), .out_ready(out_ready),
    .out_addr(oaddr_b), .out_data(odata_b), .out_last(olast_b), .busy(busy_b), .done(done_b));

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic        l;
    int          t;
  } beat_t;

  typedef struct {
    logic [31:0] mask;
    int          n;
    int          first;
    int          lst;
  } vec_t;

  beat_t got_a[$];
  beat_t got_b[$];
  int    rdb_seq[$];
  int    checks = 0;
  int    errors = 0;
  int    tk = 0;
  int    done_a_cnt = 0;
  int    done_b_cnt = 0;
  int    last_done_tk = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (tick %0d)", nm, act, exp, tk);
    end
  endtask

  // One clock: drive inputs, log handshakes seen at this edge, then observe post-edge.
  task automatic cyc(input logic st, input logic ab, input logic rdy, input logic [31:0] m);
    logic        hold;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        pl;
    start = st; abort = ab; out_ready = rdy; sel_mask = m;
    pa = oaddr_a; pd = odata_a; pl = olast_a;
    if (ovalid_a && rdy) got_a.push_back('{a: oaddr_a, d: odata_a, l: olast_a, t: tk});
    if (ovalid_b && rdy) got_b.push_back('{a: oaddr_b, d: odata_b, l: olast_b, t: tk});
    hold = ovalid_a && !rdy && !ab;
    @(posedge clk); #1;
    tk++;
    if (done_a) begin done_a_cnt++; last_done_tk = tk; end
    if (done_b) done_b_cnt++;
    if (busy_b && (rdb_seq.size() == 0 || rdb_seq[$] != int'(rd_b))) rdb_seq.push_back(int'(rd_b));
    if (hold) begin
      chk("hold_valid", ovalid_a, 1'b1);
      chk("hold_addr", oaddr_a, pa);
      chk("hold_data", odata_a, pd);
      chk("hold_last", olast_a, pl);
    end
  endtask

  task automatic load_rf();
    load_all = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 32'h0);
    load_all = 1'b0;
  endtask

  task automatic run_out(input int maxc);
    for (int c = 0; c < maxc && busy_a; c++) cyc(1'b0, 1'b0, 1'b1, 32'h0);
    chk("finish_busy", busy_a, 1'b0);
  endtask

  // Model: dut_a dumps set bits 1..31 of the mask in ascending order, data from the image.
  task automatic check_beats(input string tag, input logic [31:0] mask, input bit full);
    int exp_a[$];
    for (int i = 1; i < 32; i++) if (mask[i]) exp_a.push_back(i);
    if (full) chk({tag, "_count"}, got_a.size(), exp_a.size());
    else      chk({tag, "_short"}, got_a.size() < exp_a.size(), 1'b1);
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
      chk({tag, "_addr"}, got_a[i].a, exp_a[i]);
      chk({tag, "_data"}, got_a[i].d, rf_img[exp_a[i]]);
      chk({tag, "_last"}, got_a[i].l, i == exp_a.size() - 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    int   d0;
    start = 0; start_b = 0; abort = 0; out_ready = 0; sel_mask = 0;
    load_all = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    for (int i = 0; i < 32; i++) rf_img[i] = i * 32'h11;

    tbl[0] = '{32'hFFFF_FFFF, 31, 1, 31};
    tbl[1] = '{32'h0000_0001, 0, 0, 0};
    tbl[2] = '{32'h0000_0000, 0, 0, 0};
    tbl[3] = '{32'h8000_0000, 1, 31, 31};
    tbl[4] = '{32'h0000_00F0, 4, 4, 7};
    tbl[5] = '{32'h0000_0006, 2, 1, 2};
    tbl[6] = '{32'h0001_0003, 2, 1, 16};
    tbl[7] = '{32'hAAAA_AAAA, 16, 1, 31};
    tbl[8] = '{32'h5555_5555, 15, 2, 30};
    tbl[9] = '{32'h0000_0003, 1, 1, 1};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", ovalid_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_rdaddr", rd_a, 5'd0);
    chk("rst_addr", oaddr_a, 5'd0);
    chk("rst_data", odata_a, 32'd0);
    chk("rst_last", olast_a, 1'b0);
    rst_n = 1'b1;
    load_rf();

    // Table of masks, sink always ready
    foreach (tbl[k]) begin
      got_a.delete();
      d0 = done_a_cnt;
      cyc(1'b1, 1'b0, 1'b1, tbl[k].mask);
      run_out(60);
      cyc(1'b0, 1'b0, 1'b1, 32'h0);
      chk("tbl_count", got_a.size(), tbl[k].n);
      chk("tbl_done", done_a_cnt - d0, 1);
      if (tbl[k].n > 0) begin
        chk("tbl_first", got_a[0].a, tbl[k].first);
        chk("tbl_lastaddr", got_a[$].a, tbl[k].lst);
      end
      check_beats("tbl", tbl[k].mask, 1'b1);
    end

    // Full dump: latency, back-to-back beats, done timing
    got_a.delete();
    cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("t1_valid_t1", ovalid_a, 1'b0);
    chk("t1_busy_t1", busy_a, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 32'h0);
    chk("t1_valid_t2", ovalid_a, 1'b1);
    chk("t1_addr_t2", oaddr_a, 5'd1);
    chk("t1_data_t2", odata_a, 32'h11);
    run_out(60);
    check_beats("t1", 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < got_a.size(); i++) chk("t1_b2b", got_a[i].t - got_a[0].t, i);
    chk("t1_done_tick", last_done_tk - got_a[$].t, 1);

    // r0 included: dut_b
    got_b.delete();
    rdb_seq.delete();
    d0 = done_b_cnt;
    start_b = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 32'h8000_0005);
    start_b = 1'b0;
    for (int c = 0; c < 20 && busy_b; c++) cyc(1'b0, 1'b0, 1'b1, 32'h0);
    chk("t2_busy", busy_b, 1'b0);
    chk("t2_count", got_b.size(), 3);
    chk("t2_done", done_b_cnt - d0, 1);
    if (got_b.size() == 3) begin
      chk("t2_a0", got_b[0].a, 5'd0);
      chk("t2_d0", got_b[0].d, 32'd0);
      chk("t2_l0", got_b[0].l, 1'b0);
      chk("t2_a1", got_b[1].a, 5'd2);
      chk("t2_d1", got_b[1].d, 32'h22);
      chk("t2_a2", got_b[2].a, 5'd31);
      chk("t2_d2", got_b[2].d, 32'd31 * 32'h11);
      chk("t2_l2", got_b[2].l, 1'b1);
    end
    chk("t2_rdseq_n", rdb_seq.size(), 3);
    if (rdb_seq.size() == 3) begin
      chk("t2_rd0", rdb_seq[0], 0);
      chk("t2_rd1", rdb_seq[1], 2);
      chk("t2_rd2", rdb_seq[2], 31);
    end

    // Empty mask
    got_a.delete();
    cyc(1'b1, 1'b0, 1'b1, 32'h0);
    chk("t3_done", done_a, 1'b1);
    chk("t3_busy", busy_a, 1'b0);
    chk("t3_valid", ovalid_a, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h0);
    chk("t3_done_pulse", done_a, 1'b0);
    chk("t3_beats", got_a.size(), 0);

    // Backpressure pattern 1,0,0,1
    got_a.delete();
    d0 = done_a_cnt;
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_00F0);
    for (int c = 1; c < 60 && busy_a; c++) cyc(1'b0, 1'b0, (c % 4 == 0) || (c % 4 == 3), 32'h0);
    chk("t4_busy", busy_a, 1'b0);
    check_beats("t4", 32'h0000_00F0, 1'b1);
    chk("t4_done", done_a_cnt - d0, 1);

    // Write on capture edge, and start while busy
    got_a.delete();
    d0 = done_a_cnt;
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_0006);
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_00FF);
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hDEAD;
    cyc(1'b0, 1'b0, 1'b1, 32'h0);
    wr_en = 1'b0;
    run_out(20);
    cyc(1'b0, 1'b0, 1'b1, 32'h0);
    check_beats("t5", 32'h0000_0006, 1'b1);
    chk("t5_done", done_a_cnt - d0, 1);
    rf_img[2] = 32'hDEAD;
    load_rf();
    rf_img[2] = 32'h22;
    load_rf();

    // Abort after three beats with sink stalled
    got_a.delete();
    d0 = done_a_cnt;
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_01FE);
    for (int c = 0; c < 20 && got_a.size() < 3; c++) cyc(1'b0, 1'b0, 1'b1, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t6_valid", ovalid_a, 1'b0);
    chk("t6_busy", busy_a, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 32'h0);
    chk("t6_nodone", done_a_cnt - d0, 0);
    chk("t6_count", got_a.size(), 3);
    check_beats("t6", 32'h0000_01FE, 1'b0);
    got_a.delete();
    d0 = done_a_cnt;
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_F0F0);
    run_out(40);
    check_beats("t6_new", 32'h0000_F0F0, 1'b1);
    chk("t6_new_done", done_a_cnt - d0, 1);

    // Start and abort together
    cyc(1'b1, 1'b1, 1'b1, 32'h0000_00F0);
    chk("sa_busy", busy_a, 1'b0);
    chk("sa_done", done_a, 1'b0);

    // Reset in the middle of a dump
    d0 = done_a_cnt;
    cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    repeat (5) cyc(1'b0, 1'b0, 1'b1, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", ovalid_a, 1'b0);
    chk("mr_busy", busy_a, 1'b0);
    chk("mr_rdaddr", rd_a, 5'd0);
    chk("mr_addr", oaddr_a, 5'd0);
    chk("mr_last", olast_a, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    got_a.delete();
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 32'h0);
    chk("mr_nodone", done_a_cnt - d0, 0);
    chk("mr_nobeats", got_a.size(), 0);

    // Randomized dumps with backpressure, stray starts and occasional abort
    for (int trial = 0; trial < 40; trial++) begin
      logic [31:0] mask;
      int          p_rdy, abort_at;
      bit          aborted;
      for (int i = 0; i < 32; i++) rf_img[i] = $urandom;
      load_rf();
      mask = $urandom;
      if (trial % 3 == 0) mask = mask & $urandom;
      if (trial % 7 == 0) mask = mask & 32'h0000_00FF;
      p_rdy = $urandom_range(30, 100);
      abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : -1;
      aborted = 1'b0;
      got_a.delete();
      d0 = done_a_cnt;
      cyc(1'b1, 1'b0, 1'b1, mask);
      for (int c = 1; c < 300 && busy_a; c++) begin
        if (c == abort_at) begin
          cyc(1'b0, 1'b1, 1'b0, 32'h0);
          aborted = 1'b1;
        end else begin
          cyc($urandom_range(0, 9) == 0, 1'b0, $urandom_range(1, 100) <= p_rdy, $urandom);
        end
      end
      chk("rnd_busy", busy_a, 1'b0);
      repeat (2) cyc(1'b0, 1'b0, 1'b1, 32'h0);
      check_beats("rnd", mask, !aborted);
      chk("rnd_done", done_a_cnt - d0, aborted ? 0 : 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
